// File: rtl/serdes_link_supervisor.sv
// serdes_link_supervisor: initiator-side supervisor for a transceiver reset controller.
// Ports: clock/reset (sync, active-high); tx_ready, rx_ready, rx_is_lockedtodata [NUM_CH],
// pll_locked (async status in); force_reset, clear_counts (user controls);
// xcvr_reset, link_up, state_code (registered status out); retry_count, loss_count (saturating).
module serdes_link_supervisor #(
    parameter int NUM_CH           = 2,
    parameter int RST_PULSE_CYCLES = 16,
    parameter int READY_TIMEOUT    = 65536,
    parameter int LOSS_DEBOUNCE    = 256,
    parameter int CNT_W            = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] tx_ready,
    input  logic [NUM_CH-1:0] rx_ready,
    input  logic [NUM_CH-1:0] rx_is_lockedtodata,
    input  logic              pll_locked,
    input  logic              force_reset,
    input  logic              clear_counts,
    output logic              xcvr_reset,
    output logic              link_up,
    output logic [1:0]        state_code,
    output logic [CNT_W-1:0]  retry_count,
    output logic [CNT_W-1:0]  loss_count
);
    localparam int SW   = 3 * NUM_CH + 1;
    localparam int T1   = RST_PULSE_CYCLES > READY_TIMEOUT ? RST_PULSE_CYCLES : READY_TIMEOUT;
    localparam int TMAX = T1 > LOSS_DEBOUNCE ? T1 : LOSS_DEBOUNCE;
    localparam int TW   = $clog2(TMAX);

    typedef enum logic [1:0] {
        RESET_ASSERT  = 2'd0,
        WAIT_READY    = 2'd1,
        LINK_UP       = 2'd2,
        LOSS_DEBOUNCE_ST = 2'd3
    } state_t;

    state_t          state, nxt;
    logic [SW-1:0]   sync1, sync2;
    logic [TW-1:0]   timer;
    logic            all_ok, retry_inc, loss_inc;

    assign all_ok = &sync2;

    // force_reset overrides every transition and cancels any same-cycle count
    always_comb begin
        nxt       = state;
        retry_inc = 1'b0;
        loss_inc  = 1'b0;
        case (state)
            RESET_ASSERT: nxt = (timer == TW'(RST_PULSE_CYCLES - 1)) ? WAIT_READY : RESET_ASSERT;
            WAIT_READY: begin
                retry_inc = !all_ok && (timer == TW'(READY_TIMEOUT - 1));
                nxt       = all_ok ? LINK_UP : (retry_inc ? RESET_ASSERT : WAIT_READY);
            end
            LINK_UP: nxt = all_ok ? LINK_UP : LOSS_DEBOUNCE_ST;
            default: begin
                loss_inc = !all_ok && (timer == TW'(LOSS_DEBOUNCE - 1));
                nxt      = all_ok ? LINK_UP : (loss_inc ? RESET_ASSERT : LOSS_DEBOUNCE_ST);
            end
        endcase
        if (force_reset) begin
            nxt       = RESET_ASSERT;
            retry_inc = 1'b0;
            loss_inc  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1       <= '0;
            sync2       <= '0;
            state       <= RESET_ASSERT;
            timer       <= '0;
            xcvr_reset  <= 1'b1;
            link_up     <= 1'b0;
            state_code  <= 2'd0;
            retry_count <= '0;
            loss_count  <= '0;
        end else begin
            sync1       <= {tx_ready, rx_ready, rx_is_lockedtodata, pll_locked};
            sync2       <= sync1;
            state       <= nxt;
            // a forced reset in RESET_ASSERT counts as a fresh entry, restarting the pulse
            timer       <= (nxt != state || force_reset) ? '0 : timer + TW'(1);
            xcvr_reset  <= nxt == RESET_ASSERT;
            link_up     <= nxt == LINK_UP || nxt == LOSS_DEBOUNCE_ST;
            state_code  <= nxt;
            retry_count <= clear_counts ? '0 : retry_count + CNT_W'(retry_inc && retry_count != '1);
            loss_count  <= clear_counts ? '0 : loss_count + CNT_W'(loss_inc && loss_count != '1);
        end
    end
endmodule

// File: tb/tb_serdes_link_supervisor.sv
// tb_serdes_link_supervisor: directed bench with a cycle-level behavioural model and literal checks.
module tb_serdes_link_supervisor;
    localparam int RST  = 4;
    localparam int RT   = 32;
    localparam int LD   = 8;
    localparam int CMAX = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] tx_ready, rx_ready, rx_is_lockedtodata;
    logic       pll_locked, force_reset, clear_counts;
    logic       xcvr_reset, link_up;
    logic [1:0] state_code;
    logic [3:0] retry_count, loss_count;

    int nchk = 0;
    int nfail = 0;
    bit started = 0;
    bit done = 0;

    // model state: phase (0..3), cycle index of phase entry, delayed status, counts
    int  cyc = 0;
    int  ph = 0;
    int  ent = 0;
    int  rc = 0;
    int  lc = 0;
    int  el, nph;
    bit  d1 = 0, d2 = 0, ok, rinc, linc;

    serdes_link_supervisor #(
        .NUM_CH(2), .RST_PULSE_CYCLES(RST), .READY_TIMEOUT(RT),
        .LOSS_DEBOUNCE(LD), .CNT_W(4)
    ) dut (
        .clock(clk), .reset(reset), .tx_ready(tx_ready), .rx_ready(rx_ready),
        .rx_is_lockedtodata(rx_is_lockedtodata), .pll_locked(pll_locked),
        .force_reset(force_reset), .clear_counts(clear_counts),
        .xcvr_reset(xcvr_reset), .link_up(link_up), .state_code(state_code),
        .retry_count(retry_count), .loss_count(loss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: status is usable two clocks after it is applied; each phase ends
    // on elapsed time or on the delayed status, with force_reset winning.
    always @(posedge clk) begin
        ok = d2;
        d2 = d1;
        d1 = &{tx_ready, rx_ready, rx_is_lockedtodata, pll_locked};
        if (reset) begin
            ph = 0; ent = cyc + 1; d1 = 0; d2 = 0; rc = 0; lc = 0;
        end else begin
            el = cyc - ent;
            nph = ph; rinc = 0; linc = 0;
            if (ph == 0 && el == RST - 1) nph = 1;
            if (ph == 1 && ok) nph = 2;
            else if (ph == 1 && el == RT - 1) begin nph = 0; rinc = 1; end
            if (ph == 2 && !ok) nph = 3;
            if (ph == 3 && ok) nph = 2;
            else if (ph == 3 && el == LD - 1) begin nph = 0; linc = 1; end
            if (force_reset) begin nph = 0; rinc = 0; linc = 0; end
            if (clear_counts) begin rc = 0; lc = 0; end
            else begin
                if (rinc && rc < CMAX) rc++;
                if (linc && lc < CMAX) lc++;
            end
            if (force_reset || nph != ph) ent = cyc + 1;
            ph = nph;
        end
        cyc++;
        started = 1;
    end

    always @(negedge clk) begin
        if (started && !done) begin
            chk("m_xcvr_reset", xcvr_reset, ph == 0);
            chk("m_link_up", link_up, ph >= 2);
            chk("m_state_code", state_code, ph);
            chk("m_retry_count", retry_count, rc);
            chk("m_loss_count", loss_count, lc);
        end
    end

    task automatic wait_state(input int code, input int budget);
        int n = 0;
        while (state_code != 2'(code) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_state", state_code, code);
    endtask

    task automatic count_state(input string name, input int code, input int exp);
        int n = 0;
        while (state_code == 2'(code) && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk(name, n, exp);
    endtask

    int n;
    int seq[$];
    bit saw, lu_ok;

    initial begin
        reset = 1; tx_ready = 2'b11; rx_ready = 2'b11; rx_is_lockedtodata = 2'b11;
        pll_locked = 1; force_reset = 0; clear_counts = 0;
        repeat (3) @(negedge clk);
        chk("reset_xcvr", xcvr_reset, 1);
        chk("reset_code", state_code, 0);
        reset = 0;

        // 1: power-up
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (xcvr_reset) n++;
            if (seq.size() == 0 || seq[$] != int'(state_code)) seq.push_back(int'(state_code));
            @(negedge clk);
        end
        chk("pu_xcvr_cycles", n, 4);
        chk("pu_seq_len", seq.size(), 3);
        chk("pu_seq_last", seq[seq.size()-1], 2);
        chk("pu_link_up", link_up, 1);

        // 2: ready timeout and retry saturation
        force_reset = 1; rx_ready = 2'b01;
        @(negedge clk);
        force_reset = 0;
        wait_state(1, 20);
        count_state("wr_cycles", 1, 32);
        count_state("ra_cycles", 0, 4);
        chk("retry_one", retry_count, 1);
        repeat (19) begin
            wait_state(1, 50);
            wait_state(0, 50);
        end
        chk("retry_sat", retry_count, 15);
        rx_ready = 2'b11;
        wait_state(2, 100);

        // 3: short glitch is absorbed
        pll_locked = 0;
        repeat (3) @(negedge clk);
        pll_locked = 1;
        saw = 0; lu_ok = 1;
        for (int i = 0; i < 15; i++) begin
            if (state_code == 2'd3) saw = 1;
            if (!link_up) lu_ok = 0;
            @(negedge clk);
        end
        chk("glitch_saw_ld", saw, 1);
        chk("glitch_link_up", lu_ok, 1);
        chk("glitch_code", state_code, 2);
        chk("glitch_loss", loss_count, 0);

        // 4: sustained loss
        rx_is_lockedtodata = 2'b01;
        wait_state(3, 10);
        count_state("ld_cycles", 3, 8);
        chk("loss_code", state_code, 0);
        chk("loss_link_up", link_up, 0);
        chk("loss_count", loss_count, 1);
        repeat (9) @(negedge clk);
        rx_is_lockedtodata = 2'b11;
        wait_state(2, 100);

        // 5: force_reset, then again one cycle into the pulse
        force_reset = 1;
        @(negedge clk);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (xcvr_reset) n++;
            force_reset = (i == 1);
            @(negedge clk);
        end
        force_reset = 0;
        chk("force_xcvr_cycles", n, 6);
        chk("force_retry", retry_count, 15);
        chk("force_loss", loss_count, 1);
        wait_state(2, 100);

        // 6: clear_counts on the timeout cycle, then reset mid WAIT_READY
        force_reset = 1; rx_ready = 2'b01;
        @(negedge clk);
        force_reset = 0;
        wait_state(1, 20);
        repeat (31) @(negedge clk);
        clear_counts = 1;
        @(negedge clk);
        clear_counts = 0;
        chk("clear_retry", retry_count, 0);
        chk("clear_code", state_code, 0);
        wait_state(1, 20);
        repeat (5) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("mid_reset_xcvr", xcvr_reset, 1);
        chk("mid_reset_link", link_up, 0);
        chk("mid_reset_code", state_code, 0);
        chk("mid_reset_retry", retry_count, 0);
        chk("mid_reset_loss", loss_count, 0);
        rx_ready = 2'b11;
        repeat (20) @(negedge clk);
        chk("final_code", state_code, 2);
        done = 1;
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
